popcount_operand_feeder: RTL and testbench
==========================================

POPCOUNT_OPERAND_FEEDER -- requirements
Module: popcount_operand_feeder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: clock edges allowed for the combinational popcount path to settle; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_ready  output  1  feeder accepts word; a beat transfers on an edge where in_valid and in_ready are both 1.
REQ-006 in_data  input  32  operand word.
REQ-007 pop_x  output  128  operand x, driven to the popcount circuit inx.
REQ-008 pop_y  output  128  operand y, driven to the popcount circuit iny.
REQ-009 pop_sum  input  8  popcount result returned from the popcount circuit sum.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result; transfer on an edge where out_valid and out_ready are both 1.
REQ-012 out_sum  output  8  captured popcount result, range 0..128.

Function
REQ-013 Each operation SHALL take exactly 8 beats: beats 0-3 fill pop_x[31:0], [63:32], [95:64], [127:96]; beats 4-7 fill pop_y in the same order.
REQ-014 FSM states SHALL be LOAD, SETTLE, HOLD; in_ready SHALL be 1 only in LOAD.
REQ-015 LOAD: a 3-bit beat counter SHALL increment per accepted beat; on the edge accepting beat 7 the counter SHALL wrap to 0 and the state SHALL go to SETTLE with the settle counter at 0.
REQ-016 Only the addressed 32-bit slice SHALL change on an accepted beat; all other pop_x/pop_y bits SHALL hold.
REQ-017 SETTLE: the settle counter SHALL increment each edge; on the edge where it equals SETTLE_CYCLES-1, pop_sum SHALL be registered into out_sum and the state SHALL go to HOLD.
REQ-018 out_valid SHALL be 1 exactly in HOLD; it SHALL first be high SETTLE_CYCLES edges after the edge accepting beat 7.
REQ-019 pop_x, pop_y and out_sum SHALL be stable throughout SETTLE and HOLD.
REQ-020 HOLD: with out_ready 0, out_valid and out_sum SHALL hold indefinitely; on the transfer edge the state SHALL return to LOAD.
REQ-021 in_valid asserted outside LOAD SHALL have no effect; no beat SHALL be accepted on the HOLD-to-LOAD transition edge.
REQ-022 pop_x and pop_y SHALL retain the previous operation's contents until overwritten beat-by-beat.
REQ-023 in_valid deasserted mid-operation SHALL stall LOAD with the beat counter and partial operands held.

Reset
REQ-024 rst_n low SHALL asynchronously force state LOAD, beat counter 0, settle counter 0, pop_x 0, pop_y 0, out_sum 0, out_valid 0.
REQ-025 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-026 Reset mid-operation in any state SHALL discard the partial operation; the next accepted beat SHALL be beat 0.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration, WORD_W=32, VEC_W=128, BEATS=8, SUM_W=8.
REQ-028 The block SHALL be pure control and storage; the popcount circuit SHALL NOT be instantiated inside it.
REQ-029 One sub-module, popcount_feeder_pack, SHALL hold the beat-addressed 256-bit operand register.
REQ-030 The testbench SHALL connect pop_x/pop_y/pop_sum to the existing 128-bit popcount circuit.

Verification
REQ-031 Eight beats of 32'h0000_0000 -> out_sum 8'h80, with out_valid high 2 edges after beat 7 when SETTLE_CYCLES=2.
REQ-032 Four beats of 32'hFFFF_FFFF then four beats of 32'h0000_0000 -> out_sum 8'h00.
REQ-033 x = y = 32'hA5A5_A5A5 repeated except y beat 4 = 32'hA5A5_A5A4 -> out_sum 8'h7F.
REQ-034 out_ready held 0 for 10 cycles in HOLD with in_valid held 1 -> out_sum stable, in_ready 0, no beat consumed; result taken on the first out_ready edge.
REQ-035 rst_n pulsed low after beat 5 -> all outputs 0 immediately; a fresh 8-beat all-zero operation then yields 8'h80.
REQ-036 in_valid toggled 1/0 every cycle through the 8 beats -> result identical to the back-to-back case, with out_valid delayed by exactly the idle cycles.

Source files
------------

// File: rtl/popcount_operand_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module : popcount_operand_feeder_pkg
// Brief  : Shared widths and FSM state encoding for the popcount operand feeder.
// Rev    : 1.0  initial release
// ============================================================================
package popcount_operand_feeder_pkg;

    localparam int WORD_W   = 32;
    localparam int VEC_W    = 128;
    localparam int BEATS    = 8;
    localparam int SUM_W    = 8;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/popcount_feeder_pack.sv
`default_nettype none
// ============================================================================
// Module : popcount_feeder_pack
// Brief  : Beat-addressed 256-bit operand register; words 0-3 form x, 4-7 form y.
// Rev    : 1.0  initial release
// ============================================================================
module popcount_feeder_pack
    import popcount_operand_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [BEAT_W-1:0] i_beat,
    input  logic [WORD_W-1:0] i_data,
    output logic [VEC_W-1:0]  o_x,
    output logic [VEC_W-1:0]  o_y
);

    logic [2*VEC_W-1:0] w_opnd;

    // One register per word so a beat only ever touches its own slice.
    genvar g;
    generate
        for (g = 0; g < BEATS; g++) begin : g_word
            logic [WORD_W-1:0] r_word;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_word <= '0;
                end else if (i_wr_en && (i_beat == BEAT_W'(g))) begin
                    r_word <= i_data;
                end
            end

            assign w_opnd[g*WORD_W +: WORD_W] = r_word;
        end
    endgenerate

    assign o_x = w_opnd[VEC_W-1:0];
    assign o_y = w_opnd[2*VEC_W-1:VEC_W];

endmodule
`default_nettype wire

// File: rtl/popcount_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module : popcount_operand_feeder
// Brief  : Streams 8 words into popcount operands, waits for settle, holds result.
// Rev    : 1.0  initial release
// ============================================================================
module popcount_operand_feeder
    import popcount_operand_feeder_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [VEC_W-1:0]  pop_x,
    output logic [VEC_W-1:0]  pop_y,
    input  logic [SUM_W-1:0]  pop_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum
);

    state_t              r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [SETTLE_W-1:0] r_settle;
    logic [SUM_W-1:0]    r_out_sum;
    logic                r_out_valid;

    logic w_accept;
    logic w_last_beat;
    logic w_settle_done;

    assign w_accept      = in_valid && (r_state == ST_LOAD);
    assign w_last_beat   = (r_beat == BEAT_W'(BEATS - 1));
    assign w_settle_done = (r_settle == SETTLE_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_beat      <= '0;
            r_settle    <= '0;
            r_out_sum   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (w_last_beat) begin
                            r_state  <= ST_SETTLE;
                            r_settle <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    // Operands have been stable since the last beat, so pop_sum is valid here.
                    if (w_settle_done) begin
                        r_out_sum   <= pop_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                        r_settle    <= '0;
                    end else begin
                        r_settle <= r_settle + SETTLE_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_LOAD;
                    end
                end
                default: begin
                    r_state     <= ST_LOAD;
                    r_beat      <= '0;
                    r_settle    <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    popcount_feeder_pack u_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr_en (w_accept),
        .i_beat  (r_beat),
        .i_data  (in_data),
        .o_x     (pop_x),
        .o_y     (pop_y)
    );

    assign in_ready  = (r_state == ST_LOAD);
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;

endmodule
`default_nettype wire

// File: tb/tb_popcount_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_popcount_operand_feeder
// Brief  : Self-checking bench with a transaction-level model of the feeder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_popcount_operand_feeder;

    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_ready;
    logic [127:0] pop_x;
    logic [127:0] pop_y;
    logic [7:0]   pop_sum;
    logic         out_valid;
    logic [7:0]   out_sum;

    int errors = 0;
    int checks = 0;

    logic [31:0] op_words [8];

    always #5 clk = ~clk;

    // Popcount circuit: number of bit positions where x and y agree.
    assign pop_sum = 8'($countones(~(pop_x ^ pop_y)));

    popcount_operand_feeder #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pop_x     (pop_x),
        .pop_y     (pop_y),
        .pop_sum   (pop_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: words received so far, edges waited since the eighth word, pending result.
    logic [31:0]  m_words [8];
    int           m_nbeats;
    int           m_wait;
    bit           m_have;
    logic [7:0]   m_sum;
    wire  [127:0] m_x = {m_words[3], m_words[2], m_words[1], m_words[0]};
    wire  [127:0] m_y = {m_words[7], m_words[6], m_words[5], m_words[4]};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_words[i] <= '0;
            m_nbeats <= 0;
            m_wait   <= 0;
            m_have   <= 1'b0;
            m_sum    <= '0;
        end else if (m_nbeats < 8) begin
            if (in_valid) begin
                m_words[m_nbeats] <= in_data;
                m_nbeats          <= m_nbeats + 1;
                m_wait            <= 0;
            end
        end else if (!m_have) begin
            if (m_wait + 1 == S) begin
                m_have <= 1'b1;
                m_sum  <= 8'($countones(~(m_x ^ m_y)));
            end
            m_wait <= m_wait + 1;
        end else if (out_ready) begin
            m_have   <= 1'b0;
            m_nbeats <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, m_nbeats < 8);
            chk("out_valid", out_valid, m_have);
            chk("out_sum", out_sum, m_sum);
            chk("pop_x", pop_x, m_x);
            chk("pop_y", pop_y, m_y);
        end
    end

    task automatic drive(input int nb, input bit toggle, output int cyc);
        cyc = 0;
        for (int i = 0; i < nb; i++) begin
            int g;
            in_valid = 1'b1;
            in_data  = op_words[i];
            g = 0;
            while (!in_ready && g < 50) begin
                @(posedge clk); #1;
                g++;
                cyc++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", 1'b0, 1'b1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            cyc++;
            if (toggle && i < nb - 1) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                @(posedge clk); #1;
                cyc++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_result(input int hold, input logic [7:0] exp);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_sum", out_sum, exp);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        chk("result", out_sum, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("released", out_valid, 1'b0);
        chk("back_to_load", in_ready, 1'b1);
    endtask

    task automatic chk_reset_zero();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 8'h00);
        chk("rst_pop_x", pop_x, 128'h0);
        chk("rst_pop_y", pop_y, 128'h0);
    endtask

    initial begin
        int cyc;
        int lat;
        int base;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_zero();
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", in_ready, 1'b1);

        // All-zero operands: every bit matches.
        for (int i = 0; i < 8; i++) op_words[i] = 32'h0000_0000;
        drive(8, 1'b0, cyc);
        wait_valid(lat);
        chk("latency_zero_op", lat, S);
        take_result(0, 8'h80);

        // x all ones, y all zeros: no bit matches.
        for (int i = 0; i < 8; i++) op_words[i] = (i < 4) ? 32'hFFFF_FFFF : 32'h0000_0000;
        drive(8, 1'b0, cyc);
        wait_valid(lat);
        take_result(0, 8'h00);

        // Single differing bit.
        for (int i = 0; i < 8; i++) op_words[i] = 32'hA5A5_A5A5;
        op_words[4] = 32'hA5A5_A5A4;
        drive(8, 1'b0, cyc);
        wait_valid(lat);
        take_result(0, 8'h7F);

        // Long back-pressure with in_valid held high; four bits differ.
        for (int i = 0; i < 8; i++) op_words[i] = 32'hF0F0_F0F0;
        op_words[7] = 32'h00F0_F0F0;
        drive(8, 1'b0, cyc);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        wait_valid(lat);
        take_result(10, 8'h7C);
        in_valid = 1'b0;

        // Reset after beat 5, then a fresh all-zero operation.
        for (int i = 0; i < 8; i++) op_words[i] = 32'hDEAD_BEEF;
        drive(6, 1'b0, cyc);
        rst_n = 1'b0;
        #1;
        chk_reset_zero();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) op_words[i] = 32'h0000_0000;
        drive(8, 1'b0, cyc);
        wait_valid(lat);
        take_result(0, 8'h80);

        // Back-to-back versus toggled in_valid: same result, 7 extra cycles.
        for (int i = 0; i < 8; i++) op_words[i] = (i < 4) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        drive(8, 1'b0, cyc);
        wait_valid(lat);
        base = cyc + lat;
        chk("b2b_cycles", base, 8 + S);
        take_result(0, 8'h40);
        drive(8, 1'b1, cyc);
        wait_valid(lat);
        chk("toggle_cycles", cyc + lat, base + 7);
        take_result(0, 8'h40);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       in_data = $urandom;
                1:       in_data = 32'h0000_0000;
                2:       in_data = 32'hFFFF_FFFF;
                default: in_data = 32'hA5A5_A5A5 ^ (32'd1 << $urandom_range(0, 31));
            endcase
            out_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                chk_reset_zero();
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
